// File: rtl/hdmi_pkg.sv
// Shared types and defaults for the HDMI output path: fetch FSM states,
// default display geometry and the burst sizing helper.
package hdmi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FLUSH,
    ST_WAIT_SPACE,
    ST_REQ,
    ST_BURST,
    ST_DONE
  } fetch_state_t;

  localparam int H_DISP_DEF       = 1920;
  localparam int V_DISP_DEF       = 1080;
  localparam int BURST_LEN_DEF    = 128;
  localparam int FIFO_DEPTH_DEF   = 2048;
  localparam int FLUSH_CYCLES_DEF = 4;

  // Next burst is the full burst size unless fewer words remain in the frame.
  function automatic logic [7:0] burst_len_f(input int words_left, input int burst_max);
    return (words_left >= burst_max) ? 8'(burst_max) : 8'(words_left);
  endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop register on a single-bit input with an edge pulse taken between
// the two stages; FALLING selects which transition produces the pulse.
module sync_edge_det #(
  parameter logic RST_VAL = 1'b0,
  parameter bit   FALLING = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic pulse
);

  logic s1_q, s1_d;
  logic s2_q, s2_d;

  always_comb begin
    s1_d = din;
    s2_d = s1_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= RST_VAL;
      s2_q <= RST_VAL;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  assign pulse = FALLING ? (s2_q & ~s1_q) : (~s2_q & s1_q);

endmodule

// File: rtl/hdmi_frame_fetch_ctrl.sv
// Per-frame SDRAM read scheduler: flushes the line FIFO at frame start, then
// issues bursts whenever the FIFO has room, tracking address and words left.
module hdmi_frame_fetch_ctrl
  import hdmi_pkg::*;
#(
  parameter int                H_DISP       = H_DISP_DEF,
  parameter int                V_DISP       = V_DISP_DEF,
  parameter int                BURST_LEN    = BURST_LEN_DEF,
  parameter int                FIFO_DEPTH   = FIFO_DEPTH_DEF,
  parameter int                ADDR_W       = 24,
  parameter logic [ADDR_W-1:0] FRAME_BASE   = '0,
  parameter int                FLUSH_CYCLES = FLUSH_CYCLES_DEF
) (
  input  logic              pixel_clk,
  input  logic              sys_rst,
  input  logic              enable,
  input  logic              video_vs,
  input  logic              data_req,
  input  logic [11:0]       fifo_level,
  output logic              fifo_flush,
  output logic              rd_req,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_len,
  input  logic              rd_ack,
  input  logic              rd_done,
  output logic              underflow,
  output logic              frame_done
);

  localparam int TOTAL = H_DISP * V_DISP;
  localparam int WL_W  = $clog2(TOTAL + 1);
  localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  fetch_state_t      state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [WL_W-1:0]   words_left_q, words_left_d;
  logic [11:0]       level_q, level_d;
  logic              rd_req_q, rd_req_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [7:0]        rd_len_q, rd_len_d;
  logic              fifo_flush_q, fifo_flush_d;
  logic              underflow_q, underflow_d;
  logic              frame_done_q, frame_done_d;
  logic              restart_pend_q, restart_pend_d;

  logic              fs, fs_go, space_ok, flush_done;
  logic [7:0]        len;

  sync_edge_det #(
    .RST_VAL (1'b1),
    .FALLING (1'b1)
  ) u_vs_edge (
    .clk   (pixel_clk),
    .rst   (sys_rst),
    .din   (video_vs),
    .pulse (fs)
  );

  // Space check runs on the registered level so it is never combinational from the FIFO.
  always_comb begin
    fs_go      = fs & enable;
    len        = burst_len_f(int'(words_left_q), BURST_LEN);
    space_ok   = (32'(level_q) + 32'(len)) <= 32'(FIFO_DEPTH);
    flush_done = (cnt_q == CNT_W'(FLUSH_CYCLES - 1));
  end

  always_ff @(posedge pixel_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      addr_q         <= FRAME_BASE;
      words_left_q   <= '0;
      level_q        <= '0;
      rd_req_q       <= 1'b0;
      rd_addr_q      <= FRAME_BASE;
      rd_len_q       <= '0;
      fifo_flush_q   <= 1'b0;
      underflow_q    <= 1'b0;
      frame_done_q   <= 1'b0;
      restart_pend_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      addr_q         <= addr_d;
      words_left_q   <= words_left_d;
      level_q        <= level_d;
      rd_req_q       <= rd_req_d;
      rd_addr_q      <= rd_addr_d;
      rd_len_q       <= rd_len_d;
      fifo_flush_q   <= fifo_flush_d;
      underflow_q    <= underflow_d;
      frame_done_q   <= frame_done_d;
      restart_pend_q <= restart_pend_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:       if (fs_go) state_d = ST_FLUSH;
      ST_FLUSH:      if (!fs_go && flush_done) state_d = ST_WAIT_SPACE;
      ST_WAIT_SPACE: begin
        if (fs_go)                   state_d = ST_FLUSH;
        else if (words_left_q == '0) state_d = ST_DONE;
        else if (space_ok)           state_d = ST_REQ;
      end
      // Ack beats a simultaneous frame start; the restart is deferred past the burst.
      ST_REQ: begin
        if (rd_ack)     state_d = ST_BURST;
        else if (fs_go) state_d = ST_FLUSH;
      end
      ST_BURST:      if (rd_done) state_d = (restart_pend_q || fs_go) ? ST_FLUSH : ST_WAIT_SPACE;
      ST_DONE:       if (fs) state_d = enable ? ST_FLUSH : ST_IDLE;
      default:       state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    level_d        = fifo_level;
    addr_d         = addr_q;
    words_left_d   = words_left_q;
    rd_addr_d      = rd_addr_q;
    rd_len_d       = rd_len_q;
    rd_req_d       = (state_d == ST_REQ);
    fifo_flush_d   = (state_q == ST_FLUSH);
    frame_done_d   = (state_q == ST_WAIT_SPACE) && !fs_go && (words_left_q == '0);
    underflow_d    = underflow_q | (data_req && (fifo_level == 12'd0));
    cnt_d          = (state_q == ST_FLUSH && state_d == ST_FLUSH && !fs_go) ? cnt_q + 1'b1 : '0;
    restart_pend_d = restart_pend_q;

    if (state_q == ST_WAIT_SPACE && state_d == ST_REQ) begin
      rd_addr_d = addr_q;
      rd_len_d  = len;
    end
    if (state_q == ST_BURST && rd_done && state_d == ST_WAIT_SPACE) begin
      addr_d       = addr_q + ADDR_W'(rd_len_q);
      words_left_d = words_left_q - WL_W'(rd_len_q);
    end
    if ((state_q == ST_BURST || (state_q == ST_REQ && rd_ack)) && fs_go)
      restart_pend_d = 1'b1;
    if (state_d != ST_BURST)
      restart_pend_d = 1'b0;
    if (state_d == ST_FLUSH) begin
      addr_d       = FRAME_BASE;
      words_left_d = WL_W'(TOTAL);
      underflow_d  = 1'b0;
    end
  end

  assign fifo_flush = fifo_flush_q;
  assign rd_req     = rd_req_q;
  assign rd_addr    = rd_addr_q;
  assign rd_len     = rd_len_q;
  assign underflow  = underflow_q;
  assign frame_done = frame_done_q;

endmodule
